// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the registered MIPS ALU control decoder:
// funct codes, 5-bit {type1,type2,type3} encodings, mul/div op codes,
// sequencer states and the pure decode function.
package alu_ctrl_pkg;

  // main-control alu_op codes
  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // ALU operation encodings, packed as {type1[1:0], type2[1:0], type3}
  localparam logic [4:0] OP_ADD = 5'b10_00_0;
  localparam logic [4:0] OP_SUB = 5'b10_01_0;
  localparam logic [4:0] OP_SLL = 5'b00_00_0;
  localparam logic [4:0] OP_SRL = 5'b00_00_1;
  localparam logic [4:0] OP_SRA = 5'b00_10_1;
  localparam logic [4:0] OP_AND = 5'b11_00_0;
  localparam logic [4:0] OP_OR  = 5'b11_01_0;
  localparam logic [4:0] OP_XOR = 5'b11_11_0;
  localparam logic [4:0] OP_NOR = 5'b11_10_0;
  localparam logic [4:0] OP_SLT = 5'b01_00_0;

  // multiply/divide unit operation codes
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] op;
    logic       is_signed;
    logic       ovf_trap;
    logic       shamt_sel;
    logic       illegal;
    logic       is_md;
    logic [1:0] md_op;
  } decode_t;

  // Every path starts from all-zero flags so no field is ever left unassigned.
  function automatic decode_t decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
    decode_t d;
    d    = '0;
    d.op = OP_ADD;
    case (alu_op)
      AOP_SUB: begin
        d.op        = OP_SUB;
        d.is_signed = 1'b1;
      end
      AOP_FUNCT: begin
        case (funct)
          FN_SLL:   d.op = OP_SLL;
          FN_SRL:   d.op = OP_SRL;
          FN_SRA:   d.op = OP_SRA;
          FN_SLLV:  begin d.op = OP_SLL; d.shamt_sel = 1'b1; end
          FN_SRLV:  begin d.op = OP_SRL; d.shamt_sel = 1'b1; end
          FN_SRAV:  begin d.op = OP_SRA; d.shamt_sel = 1'b1; end
          FN_ADD:   begin d.op = OP_ADD; d.is_signed = 1'b1; d.ovf_trap = 1'b1; end
          FN_ADDU:  d.op = OP_ADD;
          FN_SUB:   begin d.op = OP_SUB; d.is_signed = 1'b1; d.ovf_trap = 1'b1; end
          FN_SUBU:  d.op = OP_SUB;
          FN_AND:   d.op = OP_AND;
          FN_OR:    d.op = OP_OR;
          FN_XOR:   d.op = OP_XOR;
          FN_NOR:   d.op = OP_NOR;
          FN_SLT:   begin d.op = OP_SLT; d.is_signed = 1'b1; end
          FN_SLTU:  d.op = OP_SLT;
          FN_MULT:  begin d.is_md = 1'b1; d.md_op = MD_MULT;  end
          FN_MULTU: begin d.is_md = 1'b1; d.md_op = MD_MULTU; end
          FN_DIV:   begin d.is_md = 1'b1; d.md_op = MD_DIV;   end
          FN_DIVU:  begin d.is_md = 1'b1; d.md_op = MD_DIVU;  end
          default:  d.illegal = 1'b1;
        endcase
      end
      default: d.op = OP_ADD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_mips_md_latency_counter.sv
// Down-counter timing a multiply/divide: loaded with latency-1 on launch,
// decremented while running, cleared by a flush. zero_o marks the final cycle.
module md_latency_counter
  import alu_ctrl_pkg::*;
#(
  parameter int CNT_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  input  logic             clear_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over load, load wins over decrement; never wraps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_ctrl_seq_mips.sv
// Registered, handshaked MIPS ALU control decoder with a multiply/divide
// sequencer. Decoded fields update the cycle after an accept; mul/div ops
// hold off new requests until the HI/LO write pulse has gone out.
module alu_ctrl_seq_mips
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic [1:0] i_alu_op_code,
  input  logic [5:0] i_funct,
  input  logic       i_flush,
  output logic       o_ready,
  output logic       o_valid,
  output logic [1:0] o_op_type_1,
  output logic [1:0] o_op_type_2,
  output logic       o_op_type_3,
  output logic       o_is_signed,
  output logic       o_ovf_trap_en,
  output logic       o_shamt_sel,
  output logic       o_illegal,
  output logic       o_md_start,
  output logic [1:0] o_md_op,
  output logic       o_busy,
  output logic       o_hilo_we
);

  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  decode_t          dec;
  logic             accept;
  logic             md_launch;
  logic             cnt_zero;
  logic [CNT_W-1:0] load_val;

  logic       valid_q, valid_d;
  logic       md_start_q, md_start_d;
  logic [4:0] op_q, op_d;
  logic       signed_q, signed_d;
  logic       trap_q, trap_d;
  logic       shamt_q, shamt_d;
  logic       illegal_q, illegal_d;
  logic [1:0] md_op_q, md_op_d;

  // Decode the request; a flush in the same cycle cancels any mul/div launch
  always_comb begin
    dec       = decode_op(i_alu_op_code, i_funct);
    accept    = i_valid && (state_q == IDLE);
    md_launch = accept && dec.is_md && !i_flush;
    load_val  = ((dec.md_op == MD_DIV) || (dec.md_op == MD_DIVU)) ? DIV_LOAD : MUL_LOAD;
  end

  // Sequencer: RUN lasts until the counter drains or a flush aborts it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (md_launch) state_d = RUN;
      RUN:     if (i_flush || cnt_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fields load on every accept and then hold; md_op only tracks mul/div requests
  always_comb begin
    valid_d    = accept && !i_flush;
    md_start_d = md_launch;
    op_d       = op_q;
    signed_d   = signed_q;
    trap_d     = trap_q;
    shamt_d    = shamt_q;
    illegal_d  = illegal_q;
    md_op_d    = md_op_q;
    if (accept) begin
      op_d      = dec.op;
      signed_d  = dec.is_signed;
      trap_d    = dec.ovf_trap;
      shamt_d   = dec.shamt_sel;
      illegal_d = dec.illegal;
      if (dec.is_md) begin
        md_op_d = dec.md_op;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      md_start_q <= 1'b0;
      op_q       <= 5'b00_00_0;
      signed_q   <= 1'b0;
      trap_q     <= 1'b0;
      shamt_q    <= 1'b0;
      illegal_q  <= 1'b0;
      md_op_q    <= MD_MULT;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      md_start_q <= md_start_d;
      op_q       <= op_d;
      signed_q   <= signed_d;
      trap_q     <= trap_d;
      shamt_q    <= shamt_d;
      illegal_q  <= illegal_d;
      md_op_q    <= md_op_d;
    end
  end

  md_latency_counter #(
    .CNT_W(CNT_W)
  ) u_md_latency_counter (
    .clk_i      (i_clk),
    .rst_ni     (i_reset),
    .load_i     (md_launch),
    .load_val_i (load_val),
    .dec_i      (state_q == RUN),
    .clear_i    (i_flush),
    .zero_o     (cnt_zero)
  );

  assign o_ready       = (state_q == IDLE);
  assign o_busy        = (state_q == RUN);
  assign o_hilo_we     = (state_q == RUN) && cnt_zero && !i_flush;
  assign o_valid       = valid_q;
  assign o_md_start    = md_start_q;
  assign o_op_type_1   = op_q[4:3];
  assign o_op_type_2   = op_q[2:1];
  assign o_op_type_3   = op_q[0];
  assign o_is_signed   = signed_q;
  assign o_ovf_trap_en = trap_q;
  assign o_shamt_sel   = shamt_q;
  assign o_illegal     = illegal_q;
  assign o_md_op       = md_op_q;

endmodule

// File: tb/tb_alu_ctrl_seq_mips.sv
// Self-checking bench for alu_ctrl_seq_mips: directed scenarios plus random
// traffic against a cycle-level reference model, and a MUL_CYCLES=1 instance.
module tb_alu_ctrl_seq_mips;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic clock;
  logic resetN;

  logic       valid, flush;
  logic [1:0] aluOp;
  logic [5:0] funct;
  logic       ready, oValid, t3, isSigned, ovfTrap, shamtSel, illegal, mdStart, busy, hiloWe;
  logic [1:0] t1, t2, mdOp;
  logic [8:0] fieldsBus;

  logic       valid1, flush1;
  logic [1:0] aluOp1;
  logic [5:0] funct1;
  logic       ready1, oValid1, t31, isSigned1, ovfTrap1, shamtSel1, illegal1, mdStart1, busy1, hiloWe1;
  logic [1:0] t11, t21, mdOp1;
  logic [8:0] fieldsBus1;

  int checkCount = 0;
  int errorCount = 0;

  int         remaining;
  logic [8:0] expFields;
  logic       expValid, expMdStart;
  logic [1:0] expMdOp;

  logic [5:0] fnList [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h18, 6'h19, 6'h1A, 6'h1B,
                              6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

  assign fieldsBus  = {t1, t2, t3, isSigned, ovfTrap, shamtSel, illegal};
  assign fieldsBus1 = {t11, t21, t31, isSigned1, ovfTrap1, shamtSel1, illegal1};

  alu_ctrl_seq_mips #(.MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .i_clk(clock), .i_reset(resetN), .i_valid(valid), .i_alu_op_code(aluOp), .i_funct(funct),
    .i_flush(flush), .o_ready(ready), .o_valid(oValid), .o_op_type_1(t1), .o_op_type_2(t2),
    .o_op_type_3(t3), .o_is_signed(isSigned), .o_ovf_trap_en(ovfTrap), .o_shamt_sel(shamtSel),
    .o_illegal(illegal), .o_md_start(mdStart), .o_md_op(mdOp), .o_busy(busy), .o_hilo_we(hiloWe)
  );

  alu_ctrl_seq_mips #(.MUL_CYCLES(1), .DIV_CYCLES(2)) dutFast (
    .i_clk(clock), .i_reset(resetN), .i_valid(valid1), .i_alu_op_code(aluOp1), .i_funct(funct1),
    .i_flush(flush1), .o_ready(ready1), .o_valid(oValid1), .o_op_type_1(t11), .o_op_type_2(t21),
    .o_op_type_3(t31), .o_is_signed(isSigned1), .o_ovf_trap_en(ovfTrap1), .o_shamt_sel(shamtSel1),
    .o_illegal(illegal1), .o_md_start(mdStart1), .o_md_op(mdOp1), .o_busy(busy1), .o_hilo_we(hiloWe1)
  );

  // free-running clock, period 10
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected {isMd, type1, type2, type3, signed, trap, shamtSel, illegal}, straight from the decode table
  function automatic logic [9:0] refDecode(input logic [1:0] op, input logic [5:0] fn);
    logic [9:0] r;
    if (op == 2'b01)      r = {1'b0, 9'b10010_1000};
    else if (op != 2'b10) r = {1'b0, 9'b10000_0000};
    else begin
      case (fn)
        6'h00: r = {1'b0, 9'b00000_0000};
        6'h02: r = {1'b0, 9'b00001_0000};
        6'h03: r = {1'b0, 9'b00101_0000};
        6'h04: r = {1'b0, 9'b00000_0010};
        6'h06: r = {1'b0, 9'b00001_0010};
        6'h07: r = {1'b0, 9'b00101_0010};
        6'h20: r = {1'b0, 9'b10000_1100};
        6'h21: r = {1'b0, 9'b10000_0000};
        6'h22: r = {1'b0, 9'b10010_1100};
        6'h23: r = {1'b0, 9'b10010_0000};
        6'h24: r = {1'b0, 9'b11000_0000};
        6'h25: r = {1'b0, 9'b11010_0000};
        6'h26: r = {1'b0, 9'b11110_0000};
        6'h27: r = {1'b0, 9'b11100_0000};
        6'h2A: r = {1'b0, 9'b01000_1000};
        6'h2B: r = {1'b0, 9'b01000_0000};
        6'h18, 6'h19, 6'h1A, 6'h1B: r = {1'b1, 9'b10000_0000};
        default: r = {1'b0, 9'b10000_0001};
      endcase
    end
    return r;
  endfunction

  task automatic modelReset();
    remaining  = 0;
    expFields  = '0;
    expValid   = 1'b0;
    expMdStart = 1'b0;
    expMdOp    = 2'b00;
  endtask

  // remaining = cycles still to spend in the mul/div before ready returns
  task automatic modelStep();
    logic       acc;
    logic [9:0] d;
    logic [5:0] mdIdx;
    acc = valid && (remaining == 0);
    d   = refDecode(aluOp, funct);
    mdIdx = funct - 6'h18;
    if (flush && remaining > 0)  remaining = 0;
    else if (remaining > 0)      remaining = remaining - 1;
    else if (acc && d[9] && !flush)
      remaining = (funct == 6'h1A || funct == 6'h1B) ? DIV_LAT : MUL_LAT;
    expValid   = acc && !flush;
    expMdStart = acc && d[9] && !flush;
    if (acc) begin
      expFields = d[8:0];
      if (d[9]) expMdOp = mdIdx[1:0];
    end
  endtask

  task automatic checkAll();
    checkOutput("ready",   {31'd0, ready},   {31'd0, remaining == 0});
    checkOutput("busy",    {31'd0, busy},    {31'd0, remaining > 0});
    checkOutput("hilo_we", {31'd0, hiloWe},  {31'd0, (remaining == 1) && !flush});
    checkOutput("valid",   {31'd0, oValid},  {31'd0, expValid});
    checkOutput("mdStart", {31'd0, mdStart}, {31'd0, expMdStart});
    checkOutput("mdOp",    {30'd0, mdOp},    {30'd0, expMdOp});
    checkOutput("fields",  {23'd0, fieldsBus}, {23'd0, expFields});
  endtask

  // Called just after a falling edge: drive, check this cycle, clock, advance model
  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] fn, input logic fl);
    valid = v; aluOp = op; funct = fn; flush = fl;
    #1;
    checkAll();
    @(posedge clock);
    modelStep();
    @(negedge clock);
  endtask

  initial begin
    int pulses;
    resetN = 1'b0;
    valid = 0; aluOp = 0; funct = 0; flush = 0;
    valid1 = 0; aluOp1 = 0; funct1 = 0; flush1 = 0;
    modelReset();
    #1;
    checkAll();
    checkOutput("reset_ready", {31'd0, ready}, 32'd1);
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;

    // decode spot checks with fixed expectations
    applyStimulus(1, 2'b10, 6'h22, 0);
    #1 checkOutput("sub_fields", {23'd0, fieldsBus}, {23'd0, 9'b10010_1100});
    checkOutput("sub_valid", {31'd0, oValid}, 32'd1);
    applyStimulus(1, 2'b10, 6'h2B, 0);
    #1 checkOutput("sltu_fields", {23'd0, fieldsBus}, {23'd0, 9'b01000_0000});
    applyStimulus(1, 2'b10, 6'h07, 0);
    #1 checkOutput("srav_fields", {23'd0, fieldsBus}, {23'd0, 9'b00101_0010});
    applyStimulus(1, 2'b10, 6'h3F, 0);
    #1 checkOutput("illegal_fields", {23'd0, fieldsBus}, {23'd0, 9'b10000_0001});
    applyStimulus(0, 2'b00, 6'h00, 0);

    // mult with a request during RUN that must be ignored
    applyStimulus(1, 2'b10, 6'h18, 0);
    applyStimulus(0, 2'b00, 6'h00, 0);
    applyStimulus(1, 2'b10, 6'h20, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b00, 6'h00, 0);

    // divu flushed on its completion cycle
    applyStimulus(1, 2'b10, 6'h1B, 0);
    for (int i = 0; i < DIV_LAT - 1; i++) applyStimulus(0, 2'b00, 6'h00, 0);
    applyStimulus(0, 2'b00, 6'h00, 1);
    applyStimulus(0, 2'b00, 6'h00, 0);
    #1 checkOutput("divu_mdop_kept", {30'd0, mdOp}, 32'd3);

    // flush in IDLE swallows the same-cycle accept
    applyStimulus(1, 2'b10, 6'h20, 1);
    applyStimulus(1, 2'b10, 6'h18, 1);
    applyStimulus(0, 2'b00, 6'h00, 0);

    // asynchronous reset in the middle of a divide
    applyStimulus(1, 2'b10, 6'h1A, 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 2'b00, 6'h00, 0);
    #1 resetN = 1'b0;
    modelReset();
    #1 checkAll();
    @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i < 40; i++) applyStimulus(0, 2'b00, 6'h00, 0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      logic [5:0] fn;
      fn = ($urandom_range(0, 3) != 0) ? fnList[$urandom_range(0, 19)] : 6'($urandom);
      if ((fn == 6'h1A || fn == 6'h1B) && $urandom_range(0, 3) != 0) fn = 6'h21;
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom), fn, $urandom_range(0, 19) == 0);
    end
    applyStimulus(0, 2'b00, 6'h00, 1);
    applyStimulus(0, 2'b00, 6'h00, 0);

    // MUL_CYCLES=1 instance: start and HI/LO write in the same cycle
    valid1 = 1; aluOp1 = 2'b10; funct1 = 6'h18;
    @(posedge clock);
    @(negedge clock);
    valid1 = 0;
    #1;
    checkOutput("fast_mdStart", {31'd0, mdStart1}, 32'd1);
    checkOutput("fast_hilo",    {31'd0, hiloWe1},  32'd1);
    checkOutput("fast_busy",    {31'd0, busy1},    32'd1);
    checkOutput("fast_mdOp",    {30'd0, mdOp1},    32'd0);
    @(negedge clock);
    #1;
    checkOutput("fast_ready_back", {31'd0, ready1}, 32'd1);
    checkOutput("fast_hilo_off",   {31'd0, hiloWe1}, 32'd0);

    // back-to-back addu accepts
    pulses = 0;
    valid1 = 1; aluOp1 = 2'b10; funct1 = 6'h21;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      if (oValid1) pulses++;
    end
    valid1 = 0;
    checkOutput("fast_b2b_pulses", pulses, 32'd8);
    checkOutput("fast_addu_fields", {23'd0, fieldsBus1}, {23'd0, 9'b10000_0000});
    @(posedge clock);
    #1;
    checkOutput("fast_valid_drop", {31'd0, oValid1}, 32'd0);
    checkOutput("fast_flags", {28'd0, illegal1, ovfTrap1, shamtSel1, isSigned1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
